// File: rtl/scatter_sched_pkg.sv
// Shared state encoding and count-width helpers for batch issuers.
package scatter_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  // Width of an offset into a batch of n entries.
  function automatic int ofs_width(input int n);
    return $clog2(n);
  endfunction

  // Width of a count that can reach n inclusive (n a power of two).
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/cnt_bits.sv
// Prefix popcounts: pre[j] = number of set bits in bits[j-1:0]; pre[N] is the total.
module cnt_bits #(
  parameter int N = 8,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0]       bits,
  output logic [N:0][W-1:0]  pre
);

  always_comb begin
    pre[0] = '0;
    for (int j = 0; j < N; j++) begin
      pre[j+1] = pre[j] + W'(bits[j]);
    end
  end

endmodule

// File: rtl/scatter.sv
// Packs consecutive input entries (from offset) into the selected output slots, lowest slot first.
// Purely combinational; unselected slots drive zero.
module scatter #(
  parameter int DATA   = 32,
  parameter int IN     = 4,
  parameter int OUT    = 8,
  parameter bit OFFSET = 1'b1,
  parameter bit ACT    = 1'b1,
  parameter int OW     = $clog2(IN)
) (
  input  logic [IN-1:0][DATA-1:0]  in_data,
  input  logic [OW-1:0]            offset,
  input  logic [OUT-1:0]           sel,
  output logic [OUT-1:0]           out_valid,
  output logic [OUT-1:0][DATA-1:0] out_data
);

  logic [OUT-1:0] sel_act;
  logic [OW-1:0]  base;
  logic [OW-1:0]  idx;

  assign sel_act = ACT ? sel : ~sel;
  assign base    = OFFSET ? offset : '0;

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    idx       = base;
    for (int j = 0; j < OUT; j++) begin
      if (sel_act[j]) begin
        out_valid[j] = 1'b1;
        out_data[j]  = in_data[idx];
        idx          = idx + OW'(1);
      end
    end
  end

endmodule

// File: rtl/scatter_sched_slot_limit.sv
// Keeps only the first `remaining` free slots (lowest index first) and reports how many were kept.
module slot_limit #(
  parameter int OUT = 8,
  parameter int CW  = 3
) (
  input  logic [OUT-1:0] slot_free,
  input  logic [CW-1:0]  remaining,
  output logic [OUT-1:0] sel,
  output logic [CW-1:0]  n
);

  localparam int PW = $clog2(OUT + 1);

  logic [OUT:0][PW-1:0] pre;
  logic [PW-1:0]        rem_ext;

  cnt_bits #(.N(OUT), .W(PW)) u_cnt (
    .bits (slot_free),
    .pre  (pre)
  );

  assign rem_ext = PW'(remaining);

  always_comb begin
    sel = '0;
    for (int j = 0; j < OUT; j++) begin
      sel[j] = slot_free[j] && (pre[j] < rem_ext);
    end
  end

  // Total is only narrowed when it is below remaining, so it always fits CW bits there.
  assign n = (pre[OUT] < rem_ext) ? pre[OUT][CW-1:0] : remaining;

endmodule

// File: rtl/scatter_sched.sv
// Holds one batch and issues it in order into free downstream slots; issue starts the cycle after accept.
// Backpressure: in_ready only in IDLE without flush; downstream slots commit with no per-slot stall.
module scatter_sched
  import scatter_sched_pkg::*;
#(
  parameter int DATA = 32,
  parameter int IN   = 4,
  parameter int OUT  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [cnt_width(IN)-1:0]  in_cnt,
  input  logic [IN-1:0][DATA-1:0]   in_data,
  input  logic [OUT-1:0]            slot_free,
  output logic [OUT-1:0]            out_valid,
  output logic [OUT-1:0][DATA-1:0]  out_data,
  output logic                      busy,
  output logic                      done
);

  localparam int OFS = ofs_width(IN);
  localparam int CW  = cnt_width(IN);

  state_e                state, state_nxt;
  logic [IN-1:0][DATA-1:0] held;
  logic [CW-1:0]         cnt;
  logic [OFS-1:0]        issued;

  logic                  active;
  logic                  accept;
  logic [CW-1:0]         remaining;
  logic [CW-1:0]         clamped;
  logic [OUT-1:0]        sel;
  logic [CW-1:0]         n;

  assign remaining = cnt - {1'b0, issued};
  assign clamped   = (in_cnt > CW'(IN)) ? CW'(IN) : in_cnt;

  // Flush masks the free vector so it also suppresses the same-cycle issue.
  slot_limit #(.OUT(OUT), .CW(CW)) u_limit (
    .slot_free (slot_free & {OUT{active}}),
    .remaining (remaining),
    .sel       (sel),
    .n         (n)
  );

  scatter #(
    .DATA(DATA), .IN(IN), .OUT(OUT), .OFFSET(1'b1), .ACT(1'b1), .OW(OFS)
  ) u_scatter (
    .in_data   (held),
    .offset    (issued),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    active    = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~flush;
        accept   = in_valid && ~flush;
        if (accept && (in_cnt != '0)) state_nxt = ISSUE;
      end
      ISSUE: begin
        busy   = 1'b1;
        active = ~flush;
        done   = active && (n == remaining);
        if (flush || done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      held   <= '0;
      cnt    <= '0;
      issued <= '0;
    end else begin
      state <= state_nxt;
      if (accept && (in_cnt != '0)) begin
        held   <= in_data;
        cnt    <= clamped;
        issued <= '0;
      end else if (state == ISSUE) begin
        if (flush || done) begin
          cnt    <= '0;
          issued <= '0;
        end else begin
          issued <= issued + n[OFS-1:0];
        end
      end
    end
  end

endmodule
